// File: rtl/pll_mode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// pll_mode_pkg : sequencer states, PLL reconfig addresses, NTSC/PAL table
// Rev 1.0
// ============================================================================
package pll_mode_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    IDLE      = 3'd2,
    MODE      = 3'd3,
    WR_REGS   = 3'd4,
    START     = 3'd5,
    WAIT_DONE = 3'd6,
    ERR       = 3'd7
  } state_t;

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C     = 6'd5;
  localparam logic [5:0] ADDR_K     = 6'd7;

  localparam int TABLE_LEN = 5;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } cfg_entry_t;

  // Row 0 NTSC (VCO 916.36 MHz), row 1 PAL (VCO 908.01 MHz); only K differs
  localparam cfg_entry_t CFG_TABLE [2][TABLE_LEN] = '{
    '{ '{ADDR_N, 32'h0001_0000}, '{ADDR_M, 32'h0000_0909}, '{ADDR_C, 32'h0000_1010},
       '{ADDR_C, 32'h0004_0404}, '{ADDR_K, 32'h53C8_D4F6} },
    '{ '{ADDR_N, 32'h0001_0000}, '{ADDR_M, 32'h0000_0909}, '{ADDR_C, 32'h0000_1010},
       '{ADDR_C, 32'h0004_0404}, '{ADDR_K, 32'h28FC_6BCB} }
  };

  function automatic cfg_entry_t table_entry(input logic pal, input logic [2:0] idx);
    return CFG_TABLE[pal][idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_mode_sequencer_sync2.sv
`default_nettype none
// ============================================================================
// sync2 : two-flop synchronizer, asynchronously cleared to 0
// Rev 1.0
// ============================================================================
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_mode_sequencer.sv
`default_nettype none
// ============================================================================
// pll_mode_sequencer : reprograms the PLL for NTSC/PAL and gates core reset
// Rev 1.0
// ============================================================================
module pll_mode_sequencer
  import pll_mode_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES     = 1048576
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode_pal,
  input  logic        pll_locked,
  output logic [5:0]  cfg_address,
  output logic        cfg_write,
  output logic [31:0] cfg_writedata,
  input  logic        cfg_waitrequest,
  output logic        core_reset_n,
  output logic        busy,
  output logic        cur_pal,
  output logic        error
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST     = 3'(TABLE_LEN - 1);

  state_t        state;
  logic          lock_s;
  logic          target;
  logic          mode_q;
  logic [2:0]    idx;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] timer;

  sync2 u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= WAIT_LOCK;
      target        <= 1'b0;
      mode_q        <= 1'b0;
      idx           <= '0;
      stable_cnt    <= '0;
      timer         <= '0;
      cfg_write     <= 1'b0;
      cfg_address   <= '0;
      cfg_writedata <= '0;
      core_reset_n  <= 1'b0;
      busy          <= 1'b1;
      cur_pal       <= 1'b0;
      error         <= 1'b0;
    end else begin
      mode_q <= mode_pal;
      unique case (state)
        IDLE: begin
          if (mode_pal != cur_pal) begin
            target        <= mode_pal;
            state         <= MODE;
            core_reset_n  <= 1'b0;
            busy          <= 1'b1;
            cfg_write     <= 1'b1;
            cfg_address   <= ADDR_MODE;
            cfg_writedata <= '0;
          end else if (!lock_s) begin
            state        <= WAIT_LOCK;
            core_reset_n <= 1'b0;
            busy         <= 1'b1;
            timer        <= '0;
          end
        end
        MODE: begin
          if (!cfg_waitrequest) begin
            state                        <= WR_REGS;
            idx                          <= '0;
            {cfg_address, cfg_writedata} <= table_entry(target, 3'd0);
          end
        end
        WR_REGS: begin
          if (!cfg_waitrequest) begin
            if (idx == IDX_LAST) begin
              state         <= START;
              cfg_address   <= ADDR_START;
              cfg_writedata <= '0;
            end else begin
              idx                          <= idx + 3'd1;
              {cfg_address, cfg_writedata} <= table_entry(target, idx + 3'd1);
            end
          end
        end
        START: begin
          if (!cfg_waitrequest) begin
            state         <= WAIT_DONE;
            cfg_write     <= 1'b0;
            cfg_address   <= '0;
            cfg_writedata <= '0;
            timer         <= '0;
          end
        end
        // The timer keeps running from WAIT_DONE into WAIT_LOCK
        WAIT_DONE: begin
          if (!cfg_waitrequest) begin
            cur_pal <= target;
            state   <= WAIT_LOCK;
            timer   <= timer + TW'(1);
          end else if (timer >= TIMEOUT_LAST) begin
            state        <= ERR;
            error        <= 1'b1;
            core_reset_n <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state      <= STABLE;
            stable_cnt <= '0;
          end else if (timer >= TIMEOUT_LAST) begin
            state        <= ERR;
            error        <= 1'b1;
            core_reset_n <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
            timer      <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state        <= IDLE;
            stable_cnt   <= '0;
            core_reset_n <= 1'b1;
            busy         <= 1'b0;
          end else begin
            stable_cnt <= stable_cnt + SW'(1);
          end
        end
        ERR: begin
          if (mode_pal != mode_q) begin
            error         <= 1'b0;
            target        <= mode_pal;
            state         <= MODE;
            cfg_write     <= 1'b1;
            cfg_address   <= ADDR_MODE;
            cfg_writedata <= '0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_mode_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pll_mode_sequencer : vector table plus random sequences vs write-list model
// Rev 1.0
// ============================================================================
module tb_pll_mode_sequencer;

  localparam int LOCK = 16;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode_pal = 1'b0;
  logic        pll_locked = 1'b0;
  logic        cfg_waitrequest = 1'b0;
  logic [5:0]  cfg_address;
  logic        cfg_write;
  logic [31:0] cfg_writedata;
  logic        core_reset_n;
  logic        busy;
  logic        cur_pal;
  logic        error;

  int checks = 0;
  int errors = 0;
  bit model_cur = 1'b0;
  bit model_err = 1'b0;

  logic [5:0]  tab_addr [5] = '{6'd3, 6'd4, 6'd5, 6'd5, 6'd7};
  logic [31:0] tab_ntsc [5] = '{32'h0001_0000, 32'h0000_0909, 32'h0000_1010, 32'h0004_0404, 32'h53C8_D4F6};
  logic [31:0] tab_pal  [5] = '{32'h0001_0000, 32'h0000_0909, 32'h0000_1010, 32'h0004_0404, 32'h28FC_6BCB};

  typedef struct {
    bit mode;
    int stall;
    int relock;
    bit glitch;
    bit exp_cur;
    int exp_wr;
  } vec_t;

  vec_t vecs [6];

  pll_mode_sequencer #(
    .LOCK_STABLE_CYCLES (LOCK),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mode_pal        (mode_pal),
    .pll_locked      (pll_locked),
    .cfg_address     (cfg_address),
    .cfg_write       (cfg_write),
    .cfg_writedata   (cfg_writedata),
    .cfg_waitrequest (cfg_waitrequest),
    .core_reset_n    (core_reset_n),
    .busy            (busy),
    .cur_pal         (cur_pal),
    .error           (error)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected write n of a full sequence: mode, five table writes, start
  task automatic exp_write(input bit pal, input int n, output logic [5:0] a, output logic [31:0] d);
    if (n == 0) begin
      a = 6'd0; d = 32'd0;
    end else if (n == 6) begin
      a = 6'd2; d = 32'd0;
    end else begin
      a = tab_addr[n-1];
      d = pal ? tab_pal[n-1] : tab_ntsc[n-1];
    end
  endtask

  // Entered and left on a falling edge
  task automatic do_seq(input bit mode, input int stall, input int relock, input bit glitch,
                        output int nw);
    logic [5:0]  ea, pa;
    logic [31:0] ed, pd;
    bit w, prev_st;
    int cyc, run, mleft, cnt;
    nw = 0; pa = '0; pd = '0;
    if (mode == model_cur && !model_err) begin
      mode_pal = mode;
      repeat (20) begin
        @(negedge clk);
        if (cfg_write) nw++;
      end
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_cur", 64'(cur_pal), 64'(model_cur));
    end else begin
      mode_pal = mode; pll_locked = 1'b0; cfg_waitrequest = 1'b0;
      @(negedge clk);
      chk("first_wr", 64'({cfg_write, cfg_address}), 64'({1'b1, 6'd0}));
      chk("err_clear", 64'(error), 64'd0);
      cyc = 0; run = 0; prev_st = 1'b0;
      mleft = (stall == 2) ? 3 : 0;
      while (nw < 7 && cyc < 40) begin
        chk("wr_active", 64'(cfg_write), 64'd1);
        if (prev_st)
          chk("wr_hold", 64'({cfg_address, cfg_writedata}), 64'({pa, pd}));
        w = 1'b0;
        if (stall == 1 && run < 3) w = ($urandom_range(0, 2) == 0);
        if (stall == 2 && cfg_address == 6'd4 && mleft > 0) begin
          w = 1'b1; mleft--;
        end
        run = w ? run + 1 : 0;
        cfg_waitrequest = w;
        if (!w && cfg_write) begin
          exp_write(mode, nw, ea, ed);
          chk($sformatf("wr%0d", nw), 64'({cfg_address, cfg_writedata}), 64'({ea, ed}));
          nw++;
        end
        prev_st = w; pa = cfg_address; pd = cfg_writedata;
        @(negedge clk);
        cyc++;
      end
      cfg_waitrequest = 1'b0;
      chk("wr_end_low", 64'(cfg_write), 64'd0);
      chk("wait_done_min", 64'(cur_pal), 64'(!mode));
      cyc = 0; run = 0;
      while (cur_pal != mode && cyc < 100) begin
        w = (stall != 0 && run < 3) ? ($urandom_range(0, 1) == 1) : 1'b0;
        run = w ? run + 1 : 0;
        cfg_waitrequest = w;
        @(negedge clk);
        cyc++;
      end
      cfg_waitrequest = 1'b0;
      chk("cur_pal", 64'(cur_pal), 64'(mode));
      chk("core_rst_low", 64'(core_reset_n), 64'd0);
      chk("busy_seq", 64'(busy), 64'd1);
      repeat (relock) @(negedge clk);
      pll_locked = 1'b1;
      if (glitch) begin
        repeat (11) @(negedge clk);
        chk("glitch_pre", 64'(core_reset_n), 64'd0);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
      end
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!core_reset_n && cnt < 200);
      // lock sampled on the first edge, +2 sync, +LOCK stable, +1 edge to observe
      chk("relock_latency", 64'(cnt), 64'(LOCK + 3));
      chk("busy_idle", 64'(busy), 64'd0);
      chk("error_low", 64'(error), 64'd0);
      model_cur = mode;
      model_err = 1'b0;
    end
  endtask

  initial begin
    int nw, cyc, cnt;
    bit tgt, m;
    int ew;

    vecs[0] = '{mode: 1'b1, stall: 2, relock: 4,  glitch: 1'b0, exp_cur: 1'b1, exp_wr: 7};
    vecs[1] = '{mode: 1'b1, stall: 0, relock: 0,  glitch: 1'b0, exp_cur: 1'b1, exp_wr: 0};
    vecs[2] = '{mode: 1'b0, stall: 1, relock: 6,  glitch: 1'b0, exp_cur: 1'b0, exp_wr: 7};
    vecs[3] = '{mode: 1'b1, stall: 1, relock: 3,  glitch: 1'b1, exp_cur: 1'b1, exp_wr: 7};
    vecs[4] = '{mode: 1'b0, stall: 0, relock: 10, glitch: 1'b0, exp_cur: 1'b0, exp_wr: 7};
    vecs[5] = '{mode: 1'b0, stall: 1, relock: 0,  glitch: 1'b0, exp_cur: 1'b0, exp_wr: 0};

    // Power-up
    repeat (3) @(negedge clk);
    chk("rst_core_reset_n", 64'(core_reset_n), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_cfg_write", 64'(cfg_write), 64'd0);
    chk("rst_cfg_address", 64'(cfg_address), 64'd0);
    chk("rst_cfg_writedata", 64'(cfg_writedata), 64'd0);
    chk("rst_cur_pal", 64'(cur_pal), 64'd0);
    reset_n = 1'b1;
    nw = 0;
    repeat (10) begin
      @(negedge clk);
      if (cfg_write) nw++;
    end
    pll_locked = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cfg_write) nw++;
    end while (!core_reset_n && cnt < 200);
    chk("pwr_latency", 64'(cnt), 64'(LOCK + 3));
    chk("pwr_busy", 64'(busy), 64'd0);
    chk("pwr_no_write", 64'(nw), 64'd0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      do_seq(vecs[i].mode, vecs[i].stall, vecs[i].relock, vecs[i].glitch, nw);
      chk($sformatf("vec%0d_writes", i), 64'(nw), 64'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_cur", i), 64'(cur_pal), 64'(vecs[i].exp_cur));
    end

    // Random requests against the write-list model
    for (int i = 0; i < 8; i++) begin
      m  = 1'($urandom_range(0, 1));
      ew = (m != model_cur) ? 7 : 0;
      do_seq(m, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), nw);
      chk($sformatf("rnd%0d_writes", i), 64'(nw), 64'(ew));
      chk($sformatf("rnd%0d_cur", i), 64'(cur_pal), 64'(m));
    end

    // Timeout with the PLL never relocking
    tgt = !model_cur;
    mode_pal = tgt; pll_locked = 1'b0; cfg_waitrequest = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(cfg_write && cfg_address == 6'd2) && cyc < 50);
    chk("tmo_start_seen", 64'(cyc < 50), 64'd1);
    for (int k = 1; k <= TMO + 1; k++) begin
      @(negedge clk);
      if (k == TMO) chk("tmo_early", 64'(error), 64'd0);
    end
    chk("tmo_error", 64'(error), 64'd1);
    chk("tmo_core_reset", 64'(core_reset_n), 64'd0);
    chk("tmo_busy", 64'(busy), 64'd1);
    model_cur = tgt;
    model_err = 1'b1;
    repeat (5) @(negedge clk);
    chk("tmo_sticky", 64'(error), 64'd1);
    do_seq(!tgt, 1, 5, 1'b0, nw);
    chk("tmo_recover_writes", 64'(nw), 64'd7);

    // Reset in the middle of the register writes
    if (!model_cur) begin
      do_seq(1'b1, 0, 2, 1'b0, nw);
      chk("pre_rst_writes", 64'(nw), 64'd7);
    end
    mode_pal = 1'b0; pll_locked = 1'b0; cfg_waitrequest = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(cfg_write && cfg_address == 6'd4) && cyc < 50);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cfg_write", 64'(cfg_write), 64'd0);
    chk("arst_cur_pal", 64'(cur_pal), 64'd0);
    chk("arst_core_reset", 64'(core_reset_n), 64'd0);
    chk("arst_busy", 64'(busy), 64'd1);
    chk("arst_cfg_address", 64'(cfg_address), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; pll_locked = 1'b1;
    cnt = 0; nw = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cfg_write) nw++;
    end while (!core_reset_n && cnt < 200);
    chk("arst_relock", 64'(cnt), 64'(LOCK + 3));
    chk("arst_no_write", 64'(nw), 64'd0);
    chk("arst_cur_after", 64'(cur_pal), 64'd0);
    model_cur = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
